// File: rtl/issue_pkg.sv
// Shared types for the integer issue queue: operand/tag widths, ALU opcodes, entry layout.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package issue_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 4;

    localparam logic [OPC_W-1:0] OPC_ADD = 4'h0;
    localparam logic [OPC_W-1:0] OPC_SUB = 4'h1;
    localparam logic [OPC_W-1:0] OPC_AND = 4'h2;
    localparam logic [OPC_W-1:0] OPC_OR  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_XOR = 4'h4;
    localparam logic [OPC_W-1:0] OPC_SLL = 4'h5;
    localparam logic [OPC_W-1:0] OPC_SRL = 4'h6;
    localparam logic [OPC_W-1:0] OPC_SLT = 4'h7;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [TAG_W-1:0]  rd_tag;
        logic [TAG_W-1:0]  rs_tag;
        logic [DATA_W-1:0] rs_data;
        logic              rs_vld;
        logic [TAG_W-1:0]  rt_tag;
        logic [DATA_W-1:0] rt_data;
        logic              rt_vld;
    } iq_entry_t;

    // Capture a CDB broadcast into any still-pending source whose tag matches.
    function automatic iq_entry_t iq_snoop(input iq_entry_t e,
                                           input logic cdb_vld,
                                           input logic [TAG_W-1:0] cdb_tag,
                                           input logic [DATA_W-1:0] cdb_data);
        iq_entry_t r;
        r = e;
        if (cdb_vld && !e.rs_vld && (e.rs_tag == cdb_tag)) begin
            r.rs_data = cdb_data;
            r.rs_vld  = 1'b1;
        end
        if (cdb_vld && !e.rt_vld && (e.rt_tag == cdb_tag)) begin
            r.rt_data = cdb_data;
            r.rt_vld  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_oldest_ready_sel.sv
// Priority select: one-hot grant and index of the lowest-numbered asserted request.
// Latency: purely combinational.
// Backpressure: none; ports req[DEPTH], gnt[DEPTH], idx, any.
module iq_oldest_ready_sel #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest asserted index is the last writer.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Collapsing reservation-station queue for one integer ALU lane, with CDB wakeup and dispatch bypass.
// Latency: ready dispatch -> Ready next cycle; CDB wakeup -> Ready the cycle after the broadcast.
// Backpressure: IssueQ_Full drops dispatches; Issue (arbiter grant) pops the oldest ready entry.
// Ports: Clk/Rst/Flush; Dispatch_* write port; CDB_* snoop; Issue grant in;
//        Ready/Issue_* selected op out; IssueQ_Full/IssueQ_Count occupancy.
// Entry storage uses issue_pkg::iq_entry_t, so width overrides must match the package.
module int_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = issue_pkg::TAG_W,
    parameter int DATA_W = issue_pkg::DATA_W,
    parameter int OPC_W  = issue_pkg::OPC_W
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Flush,
    input  logic                         Dispatch_En,
    input  logic [OPC_W-1:0]             Dispatch_Opcode,
    input  logic [TAG_W-1:0]             Dispatch_Rd_Tag,
    input  logic [TAG_W-1:0]             Dispatch_Rs_Tag,
    input  logic [TAG_W-1:0]             Dispatch_Rt_Tag,
    input  logic [DATA_W-1:0]            Dispatch_Rs_Data,
    input  logic [DATA_W-1:0]            Dispatch_Rt_Data,
    input  logic                         Dispatch_Rs_Valid,
    input  logic                         Dispatch_Rt_Valid,
    input  logic [TAG_W-1:0]             CDB_Tag,
    input  logic [DATA_W-1:0]            CDB_Data,
    input  logic                         CDB_Valid,
    input  logic                         Issue,
    output logic                         Ready,
    output logic [OPC_W-1:0]             Issue_Opcode,
    output logic [TAG_W-1:0]             Issue_Rd_Tag,
    output logic [DATA_W-1:0]            Issue_Rs_Data,
    output logic [DATA_W-1:0]            Issue_Rt_Data,
    output logic                         IssueQ_Full,
    output logic [$clog2(DEPTH+1)-1:0]   IssueQ_Count
);

    import issue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        ent_q [DEPTH];
    iq_entry_t        ent_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_shift;

    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] sel_gnt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    iq_entry_t        iss_ent;
    iq_entry_t        new_ent;
    logic             do_issue;
    logic             do_disp;

    // Readiness looks only at registered state; a same-cycle CDB hit waits a cycle.
    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = (CNT_W'(i) < cnt_q) && ent_q[i].rs_vld && ent_q[i].rt_vld;
        end
    end

    iq_oldest_ready_sel #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .req (rdy_vec),
        .gnt (sel_gnt),
        .idx (sel_idx),
        .any (sel_any)
    );

    // One-hot AND-OR mux; an empty grant yields all-zero issue outputs.
    always_comb begin
        iss_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_gnt[i]) begin
                iss_ent = iq_entry_t'(iss_ent | ent_q[i]);
            end
        end
    end

    assign Ready         = sel_any;
    assign Issue_Opcode  = iss_ent.opcode;
    assign Issue_Rd_Tag  = iss_ent.rd_tag;
    assign Issue_Rs_Data = iss_ent.rs_data;
    assign Issue_Rt_Data = iss_ent.rt_data;
    assign IssueQ_Full   = (cnt_q == CNT_W'(DEPTH));
    assign IssueQ_Count  = cnt_q;

    // Full is judged on the pre-edge count, so an issue cannot make room for a dispatch.
    assign do_issue  = Issue & sel_any;
    assign do_disp   = Dispatch_En & ~IssueQ_Full;
    assign cnt_shift = cnt_q - CNT_W'(do_issue);

    always_comb begin
        new_ent         = '0;
        new_ent.opcode  = Dispatch_Opcode;
        new_ent.rd_tag  = Dispatch_Rd_Tag;
        new_ent.rs_tag  = Dispatch_Rs_Tag;
        new_ent.rs_data = Dispatch_Rs_Data;
        new_ent.rs_vld  = Dispatch_Rs_Valid;
        new_ent.rt_tag  = Dispatch_Rt_Tag;
        new_ent.rt_data = Dispatch_Rt_Data;
        new_ent.rt_vld  = Dispatch_Rt_Valid;
    end

    // Next state in three passes: collapse over the issued slot, append the
    // dispatch at the new tail, then snoop the CDB on everything that ends up
    // occupied (this also provides the dispatch bypass).
    always_comb begin
        cnt_d = cnt_shift + CNT_W'(do_disp);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_issue && (IDX_W'(i) >= sel_idx)) begin
                ent_d[i] = ent_q[i + 1];
            end
        end
        if (do_issue) begin
            ent_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_disp && (CNT_W'(i) == cnt_shift)) begin
                ent_d[i] = new_ent;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < cnt_d) begin
                ent_d[i] = iq_snoop(ent_d[i], CDB_Valid, CDB_Tag, CDB_Data);
            end
        end
        if (Flush) begin
            cnt_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
